// File: rtl/mips_mc_sequencer.sv
// Main control FSM of the multicycle MIPS core.
// The FSM is Moore: every datapath strobe is decoded from the state register.
// The one exception is illegal_o, which also looks at the opcode held in IR.
// An instruction is fetched as four byte loads into IR.
// It is then decoded and stepped through its execute, memory and writeback states.
// run_i is only sampled in IDLE and in the final state of an instruction.
// State encoding (state_o): 0 IDLE, 1-4 FETCH1-4, 5 DECODE, 6 MADR, 7 MRD,
// 8 MWB, 9 MWR, 10 RTEX, 11 RTWB, 12 ADDIEX, 13 ADDIWB, 14 BEQ, 15 JMP.
module mips_mc_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [31:0]      instr,
    output logic             fetch_en,
    output logic             IorD,
    output logic             MemWrite,
    output logic [3:0]       IRWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             Branch,
    output logic             PCWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             busy_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_FETCH3 = 4'd3,
        S_FETCH4 = 4'd4,
        S_DECODE = 4'd5,
        S_MADR   = 4'd6,
        S_MRD    = 4'd7,
        S_MWB    = 4'd8,
        S_MWR    = 4'd9,
        S_RTEX   = 4'd10,
        S_RTWB   = 4'd11,
        S_ADDIEX = 4'd12,
        S_ADDIWB = 4'd13,
        S_BEQ    = 4'd14,
        S_JMP    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic [5:0]       opcode;
    logic             is_final;
    logic             unused_instr;

    assign opcode       = instr[31:26];
    // Only the opcode field steers the sequencer; the other fields feed the datapath.
    assign unused_instr = ^instr[25:0];
    assign is_final     = state_q inside {S_MWB, S_MWR, S_RTWB, S_ADDIWB, S_BEQ, S_JMP};

    // State register and retired-instruction counter, with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (is_final)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Next-state logic: opcode dispatch in DECODE, run_i gating at instruction boundaries.
    // NOTE: state_d gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = run_i ? S_FETCH1 : S_IDLE;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_FETCH4;
            S_FETCH4: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_LW, OP_SW: state_d = S_MADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JMP;
                    // An illegal opcode behaves like a final state with nothing to retire.
                    default:      state_d = run_i ? S_FETCH1 : S_IDLE;
                endcase
            end
            S_MADR:   state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:    state_d = S_MWB;
            S_RTEX:   state_d = S_RTWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MWB, S_MWR, S_RTWB, S_ADDIWB, S_BEQ, S_JMP:
                      state_d = run_i ? S_FETCH1 : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode; anything a state does not mention stays 0.
    always_comb begin
        fetch_en  = 1'b0;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 4'b0000;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSrc     = 2'b00;
        Branch    = 1'b0;
        PCWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        illegal_o = 1'b0;
        unique case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                // The PC is bumped by 1 on each byte, so it advances 4 per instruction.
                fetch_en = 1'b1;
                IRWrite  = 4'b0001 << (state_q - S_FETCH1);
                ALUSrcB  = 2'b01;
                PCWrite  = 1'b1;
            end
            S_DECODE: begin
                // The branch target is computed early and lands in ALUOut.
                ALUSrcB   = 2'b11;
                illegal_o = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
            end
            S_MADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MRD:    IorD = 1'b1;
            S_MWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_RTEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RTWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            S_JMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o    = (state_q != S_IDLE);
    assign retired_o = retired_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Directed bench for the multicycle MIPS control sequencer.
// It walks each instruction class state by state and checks the state and all strobes.
// It also checks the debug flags and the retired counter.
module tb_mips_mc_sequencer;

    localparam int CNT_W = 32;

    localparam logic [3:0] ST_IDLE = 4'd0,  ST_F1 = 4'd1,  ST_F2 = 4'd2,  ST_F3 = 4'd3,
                           ST_F4   = 4'd4,  ST_DEC = 4'd5, ST_MADR = 4'd6, ST_MRD = 4'd7,
                           ST_MWB  = 4'd8,  ST_MWR = 4'd9, ST_RTEX = 4'd10, ST_RTWB = 4'd11,
                           ST_ADDIEX = 4'd12, ST_ADDIWB = 4'd13, ST_BEQ = 4'd14, ST_JMP = 4'd15;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             run_i = 1'b1;
    logic [31:0]      instr = 32'h0;
    logic             fetch_en, IorD, MemWrite, RegWrite, ALUSrcA, Branch, PCWrite, RegDst, MemtoReg;
    logic [3:0]       IRWrite;
    logic [1:0]       ALUSrcB, ALUOp, PCSrc;
    logic             busy_o, illegal_o;
    logic [CNT_W-1:0] retired_o;
    logic [3:0]       state_o;

    int total = 0;
    int bad   = 0;

    mips_mc_sequencer #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .instr(instr),
        .fetch_en(fetch_en), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .Branch(Branch), .PCWrite(PCWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .busy_o(busy_o), .illegal_o(illegal_o),
        .retired_o(retired_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    // Pack the strobes in a fixed order:
    // fetch_en, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Branch, PCWrite, RegDst, MemtoReg.
    function automatic logic [18:0] mk(logic fe, logic iord, logic mw, logic [3:0] irw, logic rw,
                                       logic sa, logic [1:0] sb, logic [1:0] op, logic [1:0] pcs,
                                       logic br, logic pcw, logic rd, logic m2r);
        return {fe, iord, mw, irw, rw, sa, sb, op, pcs, br, pcw, rd, m2r};
    endfunction

    function automatic logic [18:0] outs();
        return {fetch_en, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSrc, Branch, PCWrite, RegDst, MemtoReg};
    endfunction

    // Hand-written table of required strobes per state.
    function automatic logic [18:0] exp_outs(logic [3:0] st);
        case (st)
            ST_F1:     return mk(1,0,0,4'b0001,0, 0,2'b01,2'b00,2'b00, 0,1,0,0);
            ST_F2:     return mk(1,0,0,4'b0010,0, 0,2'b01,2'b00,2'b00, 0,1,0,0);
            ST_F3:     return mk(1,0,0,4'b0100,0, 0,2'b01,2'b00,2'b00, 0,1,0,0);
            ST_F4:     return mk(1,0,0,4'b1000,0, 0,2'b01,2'b00,2'b00, 0,1,0,0);
            ST_DEC:    return mk(0,0,0,4'b0000,0, 0,2'b11,2'b00,2'b00, 0,0,0,0);
            ST_MADR:   return mk(0,0,0,4'b0000,0, 1,2'b10,2'b00,2'b00, 0,0,0,0);
            ST_MRD:    return mk(0,1,0,4'b0000,0, 0,2'b00,2'b00,2'b00, 0,0,0,0);
            ST_MWB:    return mk(0,0,0,4'b0000,1, 0,2'b00,2'b00,2'b00, 0,0,0,1);
            ST_MWR:    return mk(0,1,1,4'b0000,0, 0,2'b00,2'b00,2'b00, 0,0,0,0);
            ST_RTEX:   return mk(0,0,0,4'b0000,0, 1,2'b00,2'b10,2'b00, 0,0,0,0);
            ST_RTWB:   return mk(0,0,0,4'b0000,1, 0,2'b00,2'b00,2'b00, 0,0,1,0);
            ST_ADDIEX: return mk(0,0,0,4'b0000,0, 1,2'b10,2'b00,2'b00, 0,0,0,0);
            ST_ADDIWB: return mk(0,0,0,4'b0000,1, 0,2'b00,2'b00,2'b00, 0,0,0,0);
            ST_BEQ:    return mk(0,0,0,4'b0000,0, 1,2'b00,2'b01,2'b01, 1,0,0,0);
            ST_JMP:    return mk(0,0,0,4'b0000,0, 0,2'b00,2'b00,2'b10, 0,1,0,0);
            default:   return '0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Walk one instruction from FETCH1 through its final state, then check where it lands.
    // illegal_at is the sequence index where illegal_o must be high, or -1 if nowhere.
    task automatic walk(input string name, input logic [31:0] ins, input logic [3:0] seq[$],
                        input int illegal_at, input int drop_run_at,
                        input logic [3:0] exp_next, input logic [CNT_W-1:0] exp_ret);
        instr = ins;
        foreach (seq[i]) begin
            total++;
            if (state_o !== seq[i]) begin
                bad++;
                $display("FAIL %s state c%0d: got %0d want %0d", name, i, state_o, seq[i]);
            end
            total++;
            if (outs() !== exp_outs(seq[i])) begin
                bad++;
                $display("FAIL %s strobes c%0d: got %b want %b", name, i, outs(), exp_outs(seq[i]));
            end
            total++;
            if (illegal_o !== (i == illegal_at) || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL %s flags c%0d: got illegal=%b busy=%b want illegal=%b busy=1",
                         name, i, illegal_o, busy_o, (i == illegal_at));
            end
            if (i == drop_run_at) run_i = 1'b0;
            step();
        end
        total++;
        if (state_o !== exp_next || retired_o !== exp_ret) begin
            bad++;
            $display("FAIL %s after: got state=%0d retired=%0d want state=%0d retired=%0d",
                     name, state_o, retired_o, exp_next, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        run_i = 1'b1;
        instr = 32'h8C410004;
        step();
        step();
        total++;
        if (state_o !== ST_IDLE || outs() !== '0 || retired_o !== '0 ||
            busy_o !== 1'b0 || illegal_o !== 1'b0) begin
            bad++;
            $display("FAIL reset: got state=%0d strobes=%b retired=%0d busy=%b illegal=%b want all 0",
                     state_o, outs(), retired_o, busy_o, illegal_o);
        end
        rst_i = 1'b0;
        step();
        total++;
        if (state_o !== ST_F1) begin
            bad++;
            $display("FAIL reset_release: got state=%0d want %0d", state_o, ST_F1);
        end
    endtask

    task automatic test_lw();
        walk("lw", 32'h8C410004, '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC, ST_MADR, ST_MRD, ST_MWB},
             -1, -1, ST_F1, 1);
    endtask

    task automatic test_beq();
        walk("beq", 32'h10220003, '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC, ST_BEQ},
             -1, -1, ST_F1, 2);
    endtask

    task automatic test_illegal();
        walk("illegal", 32'hFC000000, '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC},
             4, -1, ST_F1, 2);
    endtask

    task automatic test_back_to_back();
        walk("sw", 32'hAC410004, '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC, ST_MADR, ST_MWR},
             -1, -1, ST_F1, 3);
        walk("addi", 32'h20410005, '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC, ST_ADDIEX, ST_ADDIWB},
             -1, -1, ST_F1, 4);
        walk("j", 32'h08000010, '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC, ST_JMP},
             -1, -1, ST_F1, 5);
    endtask

    task automatic test_run_drop();
        // run_i falls during RTEX; the R-type still completes, then the FSM parks in IDLE.
        walk("rtype_drop", 32'h00221820, '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC, ST_RTEX, ST_RTWB},
             -1, 5, ST_IDLE, 6);
        step();
        total++;
        if (state_o !== ST_IDLE || busy_o !== 1'b0 || outs() !== '0) begin
            bad++;
            $display("FAIL idle_hold: got state=%0d busy=%b strobes=%b want IDLE, 0, 0",
                     state_o, busy_o, outs());
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq[$] = '{ST_F1, ST_F2, ST_F3, ST_F4, ST_DEC, ST_MADR, ST_MRD};
        instr = 32'h8C410004;
        run_i = 1'b1;
        step();
        foreach (seq[i]) begin
            total++;
            if (state_o !== seq[i] || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid c%0d: got state=%0d MemWrite=%b RegWrite=%b want state=%0d 0 0",
                         i, state_o, MemWrite, RegWrite, seq[i]);
            end
            if (i == seq.size() - 1) rst_i = 1'b1;
            step();
        end
        total++;
        if (state_o !== ST_IDLE || retired_o !== '0 || outs() !== '0) begin
            bad++;
            $display("FAIL rst_mid_after: got state=%0d retired=%0d strobes=%b want IDLE 0 0",
                     state_o, retired_o, outs());
        end
        rst_i = 1'b0;
        run_i = 1'b0;
        step();
        total++;
        if (state_o !== ST_IDLE || retired_o !== '0) begin
            bad++;
            $display("FAIL rst_mid_idle: got state=%0d retired=%0d want IDLE 0", state_o, retired_o);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_run_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
